// File: rtl/mod_compress_if.sv
// Block-level signal bundle between the SHA-256 compression engine and its
// controller / W schedule source.
interface mod_compress_if;
  logic         START;
  logic         INIT;
  logic [5:0]   I;
  logic [31:0]  W_IN;
  logic         BUSY;
  logic         DONE;
  logic [255:0] DIGEST;

  modport master (output START, INIT, W_IN, input I, BUSY, DONE, DIGEST);
  modport slave  (input START, INIT, W_IN, output I, BUSY, DONE, DIGEST);
endinterface

// File: rtl/mod_compress.sv
// SHA-256 compression engine: 64 rounds over W words fetched by index I,
// then folds the working variables into the chaining state H.
module mod_compress (
  input  logic          CLK,
  input  logic          RST_N,
  mod_compress_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  // v holds the working variables a..h as v[0]..v[7]
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic        done_q, done_d;
  logic [31:0] t1, t2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV[i];
        v_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= h_d[i];
        v_q[i] <= v_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = ROUND;
      ROUND:   if (t_q == 6'd63) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d    = t_q;
    h_d    = h_q;
    v_d    = v_q;
    done_d = 1'b0;
    t1     = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K_ROM[t_q] + bus.W_IN;
    t2     = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          t_d = '0;
          if (bus.INIT) begin
            h_d = IV;
            v_d = IV;
          end else begin
            v_d = h_q;
          end
        end
      end
      ROUND: begin
        for (int i = 7; i > 0; i--) v_d[i] = v_q[i-1];
        v_d[4] = v_q[3] + t1;
        v_d[0] = t1 + t2;
        // wraps 63 -> 0, so I reads 0 again in FINAL and IDLE
        t_d    = t_q + 6'd1;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.I      = t_q;
    bus.BUSY   = (state_q != IDLE);
    bus.DONE   = done_q;
    bus.DIGEST = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  end

endmodule
